// File: rtl/shim_sts_latch_if.sv
// ---------------------------------------------------------------------------
// shim_sts_latch_if
//   Bundles the status inputs and the latched/recorded outputs of the
//   shim status latch. The parameters must match those of the
//   shim_sts_latch instance connected to it.
//
//   master : drives sts_in, field_mask and clear; observes the results.
//   slave  : the latch itself.
//
//   sts_in       status flags, field f / channel c at bit f*CHANNELS+c
//   field_mask   per-field enable for latching, first-fault and counting
//   clear        clear request (re-clears on every cycle it is high)
//   sts_sticky   sticky event bits, same layout as sts_in
//   first_valid  a first fault has been recorded
//   first_field  field index of the first fault
//   first_ch     channel index of the first fault
//   first_ts     timestamp of the first fault
//   fault_cnt    saturating count of cycles with at least one masked event
//   ts_now       free-running timestamp
//   irq          interrupt, mirrors first_valid
// ---------------------------------------------------------------------------
interface shim_sts_latch_if #(
  parameter int CHANNELS   = 8,
  parameter int NUM_FIELDS = 16,
  parameter int TS_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
);
  localparam int SW = NUM_FIELDS * CHANNELS;
  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [SW-1:0]         sts_in;
  logic [NUM_FIELDS-1:0] field_mask;
  logic                  clear;
  logic [SW-1:0]         sts_sticky;
  logic                  first_valid;
  logic [FW-1:0]         first_field;
  logic [CW-1:0]         first_ch;
  logic [TS_WIDTH-1:0]   first_ts;
  logic [CNT_WIDTH-1:0]  fault_cnt;
  logic [TS_WIDTH-1:0]   ts_now;
  logic                  irq;

  modport master (
    output sts_in, field_mask, clear,
    input  sts_sticky, first_valid, first_field, first_ch, first_ts,
           fault_cnt, ts_now, irq
  );

  modport slave (
    input  sts_in, field_mask, clear,
    output sts_sticky, first_valid, first_field, first_ch, first_ts,
           fault_cnt, ts_now, irq
  );
endinterface

// File: rtl/shim_sts_latch.sv
// ---------------------------------------------------------------------------
// shim_sts_latch
//   Status latch and first-fault recorder for the AXI clock domain.
//   Inputs are assumed already synchronised to aclk. Each status bit is
//   turned into an event (rising edge or level, per EDGE_MODE), gated by
//   its field's mask bit, and OR-ed into a sticky register. The lowest
//   (field, channel) event seen while no record is held is captured along
//   with the timestamp, cycles containing events are counted with
//   saturation, and irq is raised until software clears it.
//
//   Ports:
//     aclk     clock
//     aresetn  asynchronous active-low reset; every register returns to 0
//     bus      shim_sts_latch_if.slave (see the interface for signal list)
// ---------------------------------------------------------------------------
module shim_sts_latch #(
  parameter int CHANNELS   = 8,
  parameter int NUM_FIELDS = 16,
  parameter int TS_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int EDGE_MODE  = 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  shim_sts_latch_if.slave bus
);
  localparam int SW = NUM_FIELDS * CHANNELS;
  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [SW-1:0]        sts_prev;
  logic [SW-1:0]        sticky_q;
  logic                 first_valid_q;
  logic [FW-1:0]        first_field_q;
  logic [CW-1:0]        first_ch_q;
  logic [TS_WIDTH-1:0]  first_ts_q;
  logic [CNT_WIDTH-1:0] fault_cnt_q;
  logic [TS_WIDTH-1:0]  ts_q;
  logic                 irq_q;

  logic [SW-1:0]        evt_p0;
  logic [SW-1:0]        mask_exp_p0;
  logic [SW-1:0]        masked_p0;
  logic                 any_p0;
  logic [FW-1:0]        enc_field_p0;
  logic [CW-1:0]        enc_ch_p0;
  logic                 capture_p0;
  logic                 first_valid_nxt_p0;

  // ---- stage p0: event detect, masking, priority encode ----
  always_comb begin
    evt_p0 = (EDGE_MODE != 0) ? (bus.sts_in & ~sts_prev) : bus.sts_in;
    mask_exp_p0 = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      mask_exp_p0[f*CHANNELS +: CHANNELS] = {CHANNELS{bus.field_mask[f]}};
    end
    masked_p0 = evt_p0 & mask_exp_p0;
    any_p0    = |masked_p0;

    // Scan from the top down so the lowest field, then lowest channel,
    // is the last assignment and therefore wins.
    enc_field_p0 = '0;
    enc_ch_p0    = '0;
    for (int f = NUM_FIELDS - 1; f >= 0; f--) begin
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (masked_p0[f*CHANNELS + c]) begin
          enc_field_p0 = f[FW-1:0];
          enc_ch_p0    = c[CW-1:0];
        end
      end
    end

    // A clear in the same cycle frees the record for this cycle's event.
    capture_p0         = any_p0 && (bus.clear || !first_valid_q);
    first_valid_nxt_p0 = any_p0 || (first_valid_q && !bus.clear);
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q          <= '0;
      sts_prev      <= '0;
      sticky_q      <= '0;
      first_valid_q <= 1'b0;
      first_field_q <= '0;
      first_ch_q    <= '0;
      first_ts_q    <= '0;
      fault_cnt_q   <= '0;
      irq_q         <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_WIDTH'(1);
      sts_prev <= bus.sts_in;
      sticky_q <= (bus.clear ? '0 : sticky_q) | masked_p0;

      first_valid_q <= first_valid_nxt_p0;
      irq_q         <= first_valid_nxt_p0;

      if (capture_p0) begin
        first_field_q <= enc_field_p0;
        first_ch_q    <= enc_ch_p0;
        first_ts_q    <= ts_q;
      end else if (bus.clear) begin
        first_field_q <= '0;
        first_ch_q    <= '0;
        first_ts_q    <= '0;
      end

      if (bus.clear) begin
        fault_cnt_q <= any_p0 ? CNT_WIDTH'(1) : '0;
      end else if (any_p0) begin
        fault_cnt_q <= sat_inc(fault_cnt_q);
      end
    end
  end

  assign bus.sts_sticky  = sticky_q;
  assign bus.first_valid = first_valid_q;
  assign bus.first_field = first_field_q;
  assign bus.first_ch    = first_ch_q;
  assign bus.first_ts    = first_ts_q;
  assign bus.fault_cnt   = fault_cnt_q;
  assign bus.ts_now      = ts_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_shim_sts_latch.sv
// ---------------------------------------------------------------------------
// tb_shim_sts_latch
//   Two latches on one clock and one stimulus stream: dut_edge (EDGE_MODE=1)
//   and dut_lvl (EDGE_MODE=0), both with 16 fields x 8 channels, an 8-bit
//   timestamp and a 4-bit counter. A behavioural model tracks both.
// ---------------------------------------------------------------------------
module tb_shim_sts_latch;
  localparam int NF = 16;
  localparam int CH = 8;
  localparam int SW = NF * CH;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  shim_sts_latch_if #(.CHANNELS(CH), .NUM_FIELDS(NF), .TS_WIDTH(8), .CNT_WIDTH(4)) if0 ();
  shim_sts_latch_if #(.CHANNELS(CH), .NUM_FIELDS(NF), .TS_WIDTH(8), .CNT_WIDTH(4)) if1 ();

  shim_sts_latch #(.CHANNELS(CH), .NUM_FIELDS(NF), .TS_WIDTH(8), .CNT_WIDTH(4), .EDGE_MODE(1))
    dut_edge (.aclk(aclk), .aresetn(aresetn), .bus(if0));
  shim_sts_latch #(.CHANNELS(CH), .NUM_FIELDS(NF), .TS_WIDTH(8), .CNT_WIDTH(4), .EDGE_MODE(0))
    dut_lvl (.aclk(aclk), .aresetn(aresetn), .bus(if1));

  int total = 0;
  int bad   = 0;
  int edges = 0;   // clock edges since the last reset release

  // ---- reference model (index 0 = edge mode, 1 = level mode) ----
  logic [SW-1:0] m_prev [2];
  logic [SW-1:0] m_sticky [2];
  bit            m_fv [2];
  int            m_ff [2];
  int            m_fc [2];
  int            m_fts [2];
  int            m_cnt [2];
  int            m_ts;

  typedef struct {
    logic [SW-1:0] sts;
    logic [NF-1:0] mask;
    logic          clr;
    logic [SW-1:0] sticky;
    logic          fv;
    int            ff;
    int            fc;
    int            cnt;
  } vec_t;
  vec_t tbl [16];

  function automatic logic [SW-1:0] bitv(input int i);
    logic [SW-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_prev[m] = '0; m_sticky[m] = '0; m_fv[m] = 0;
      m_ff[m] = 0; m_fc[m] = 0; m_fts[m] = 0; m_cnt[m] = 0;
    end
    m_ts = 0;
  endtask

  task automatic model_edge(input logic [SW-1:0] s, input logic [NF-1:0] mk, input logic c);
    logic [SW-1:0] mexp, ev, mev;
    int lo;
    for (int f = 0; f < NF; f++) mexp[f*CH +: CH] = {CH{mk[f]}};
    for (int m = 0; m < 2; m++) begin
      ev = (m == 0) ? (s & ~m_prev[m]) : s;
      m_prev[m] = s;
      mev = ev & mexp;
      if (c) begin
        m_sticky[m] = '0; m_fv[m] = 0; m_ff[m] = 0; m_fc[m] = 0; m_fts[m] = 0; m_cnt[m] = 0;
      end
      m_sticky[m] |= mev;
      if (mev != '0) begin
        if (m_cnt[m] < 15) m_cnt[m]++;
        if (!m_fv[m]) begin
          lo = -1;
          for (int i = 0; i < SW; i++) if (mev[i] && lo < 0) lo = i;
          m_ff[m] = lo / CH; m_fc[m] = lo % CH; m_fts[m] = m_ts; m_fv[m] = 1;
        end
      end
    end
    m_ts = (m_ts + 1) % 256;
  endtask

  task automatic check_all();
    chk("e_sticky", if0.sts_sticky, m_sticky[0]);
    chk("e_fv",     if0.first_valid, m_fv[0]);
    chk("e_ff",     if0.first_field, m_ff[0]);
    chk("e_fc",     if0.first_ch, m_fc[0]);
    chk("e_fts",    if0.first_ts, m_fts[0]);
    chk("e_cnt",    if0.fault_cnt, m_cnt[0]);
    chk("e_irq",    if0.irq, m_fv[0]);
    chk("e_ts",     if0.ts_now, m_ts);
    chk("l_sticky", if1.sts_sticky, m_sticky[1]);
    chk("l_fv",     if1.first_valid, m_fv[1]);
    chk("l_ff",     if1.first_field, m_ff[1]);
    chk("l_fc",     if1.first_ch, m_fc[1]);
    chk("l_fts",    if1.first_ts, m_fts[1]);
    chk("l_cnt",    if1.fault_cnt, m_cnt[1]);
    chk("l_irq",    if1.irq, m_fv[1]);
    chk("l_ts",     if1.ts_now, m_ts);
  endtask

  // Called with aclk low; applies inputs, takes one edge, checks at negedge.
  task automatic step(input logic [SW-1:0] s, input logic [NF-1:0] mk, input logic c);
    if0.sts_in = s; if0.field_mask = mk; if0.clear = c;
    if1.sts_in = s; if1.field_mask = mk; if1.clear = c;
    @(posedge aclk);
    edges++;
    model_edge(s, mk, c);
    @(negedge aclk);
    check_all();
  endtask

  initial begin
    logic [SW-1:0] s;
    logic [NF-1:0] mk;
    logic c;
    int k0;

    // Expected results for dut_edge, starting at reset release.
    tbl[0]  = '{bitv(17), 16'hFFFF, 0, bitv(17), 1, 2, 1, 1};
    tbl[1]  = '{bitv(17), 16'hFFFF, 0, bitv(17), 1, 2, 1, 1};
    tbl[2]  = '{'0, 16'hFFFF, 1, '0, 0, 0, 0, 0};
    tbl[3]  = '{bitv(43) | bitv(14), 16'hFFFF, 0, bitv(43) | bitv(14), 1, 1, 6, 1};
    tbl[4]  = '{'0, 16'hFFFF, 0, bitv(43) | bitv(14), 1, 1, 6, 1};
    tbl[5]  = '{'0, 16'hFFFF, 1, '0, 0, 0, 0, 0};
    tbl[6]  = '{bitv(32), 16'hFFEF, 0, '0, 0, 0, 0, 0};
    tbl[7]  = '{'0, 16'hFFEF, 0, '0, 0, 0, 0, 0};
    tbl[8]  = '{bitv(32), 16'hFFFF, 0, bitv(32), 1, 4, 0, 1};
    tbl[9]  = '{'0, 16'hFFFF, 0, bitv(32), 1, 4, 0, 1};
    tbl[10] = '{'0, 16'hFFFF, 1, '0, 0, 0, 0, 0};
    tbl[11] = '{bitv(24), 16'hFFFF, 0, bitv(24), 1, 3, 0, 1};
    tbl[12] = '{'0, 16'hFFFF, 0, bitv(24), 1, 3, 0, 1};
    tbl[13] = '{bitv(0), 16'hFFFF, 1, bitv(0), 1, 0, 0, 1};
    tbl[14] = '{bitv(0), 16'hFFFF, 0, bitv(0), 1, 0, 0, 1};
    tbl[15] = '{'0, 16'hFFFE, 0, bitv(0), 1, 0, 0, 1};

    // Reset state.
    if0.sts_in = '0; if0.field_mask = '1; if0.clear = 0;
    if1.sts_in = '0; if1.field_mask = '1; if1.clear = 0;
    model_reset();
    @(negedge aclk);
    @(negedge aclk);
    check_all();

    // Release reset with bit 17 already high, then run the vector table.
    if0.sts_in = bitv(17); if1.sts_in = bitv(17);
    aresetn = 1'b1;
    edges = 0;
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].sts, tbl[i].mask, tbl[i].clr);
      chk($sformatf("tbl%0d_sticky", i), if0.sts_sticky, tbl[i].sticky);
      chk($sformatf("tbl%0d_fv", i), if0.first_valid, tbl[i].fv);
      chk($sformatf("tbl%0d_irq", i), if0.irq, tbl[i].fv);
      chk($sformatf("tbl%0d_ff", i), if0.first_field, tbl[i].ff);
      chk($sformatf("tbl%0d_fc", i), if0.first_ch, tbl[i].fc);
      chk($sformatf("tbl%0d_cnt", i), if0.fault_cnt, tbl[i].cnt);
      if (i == 0) chk("rst_first_ts", if0.first_ts, 0);
    end

    // Level mode saturation: hold one bit for 20 cycles.
    step('0, 16'hFFFF, 1);
    k0 = edges + 1;
    for (int i = 0; i < 20; i++) step(bitv(50), 16'hFFFF, 0);
    chk("sat_cnt", if1.fault_cnt, 15);
    chk("sat_fts", if1.first_ts, (k0 - 1) % 256);
    chk("sat_ff", if1.first_field, 6);
    chk("sat_fc", if1.first_ch, 2);
    chk("sat_edge_cnt", if0.fault_cnt, 1);

    // Asynchronous reset between edges, observed before the next edge.
    step(bitv(77), 16'hFFFF, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_sticky", if0.sts_sticky, '0);
    chk("arst_fv", if0.first_valid, 0);
    chk("arst_irq", if0.irq, 0);
    chk("arst_cnt", if1.fault_cnt, 0);
    chk("arst_ts", if0.ts_now, 0);
    chk("arst_lsticky", if1.sts_sticky, '0);
    model_reset();
    @(negedge aclk);
    check_all();

    // Timestamp wrap: 299 quiet cycles after release, then one event.
    if0.sts_in = '0; if1.sts_in = '0;
    aresetn = 1'b1;
    edges = 0;
    for (int i = 0; i < 299; i++) step('0, 16'hFFFF, 0);
    step(bitv(100), 16'hFFFF, 0);
    chk("wrap_fts", if0.first_ts, (edges - 1) % 256);
    chk("wrap_ff", if0.first_field, 12);
    chk("wrap_fc", if0.first_ch, 4);

    // Randomised run against the model.
    s = '0;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) s[$urandom_range(0, SW - 1)] ^= 1'b1;
      mk = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '1;
      c  = ($urandom_range(0, 15) == 0);
      step(s, mk, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shim_sts_latch.md
# shim_sts_latch

Parametrised status latch and first-fault recorder for the shim's AXI clock domain. It takes status vectors already synchronised into the AXI domain (NUM_FIELDS flags × CHANNELS channels), detects new events per bit, and holds them as sticky bits. It records the first fault's field, channel and timestamp, counts fault cycles, and drives an interrupt until software clears it.

## Interface
- CHANNELS, 8: channels per status field (1..32).
- NUM_FIELDS, 16: number of status fields (1..32).
- TS_WIDTH, 32: free-running timestamp width (8..64).
- CNT_WIDTH, 16: fault-cycle counter width (4..32).
- EDGE_MODE, 1: 1 = only a 0→1 input transition is an event; 0 = any asserted input bit is an event every cycle.

Ports:
- aclk  in  1  AXI domain clock (single clock for the whole block).
- aresetn  in  1  reset, asynchronous, active-low.
- sts_in  in  NUM_FIELDS*CHANNELS  flattened status; field f, channel c at bit f*CHANNELS+c.
- field_mask  in  NUM_FIELDS  1 = field enabled for latching, first-fault and count.
- clear  in  1  single-cycle clear request.
- sts_sticky  out  NUM_FIELDS*CHANNELS  sticky event bits, same layout as sts_in.
- first_valid  out  1  first fault recorded.
- first_field  out  max(1,clog2(NUM_FIELDS))  field index of the first fault.
- first_ch  out  max(1,clog2(CHANNELS))  channel index of the first fault.
- first_ts  out  TS_WIDTH  timestamp of the first fault.
- fault_cnt  out  CNT_WIDTH  saturating count of cycles containing ≥1 masked event.
- ts_now  out  TS_WIDTH  current timestamp counter.
- irq  out  1  registered; equals first_valid.

## Operation
- Timestamp counter ts:
  - Increments by 1 every cycle.
  - Wraps from all-ones to 0.
  - Not affected by clear.
- Edge detect (EDGE_MODE=1):
  - sts_prev registers sts_in every cycle; event = sts_in & ~sts_prev.
  - sts_prev resets to 0, so a bit already high at reset release produces one event.
- Level mode (EDGE_MODE=0): event = sts_in.
- Masking: masked_event = event & expanded field_mask, where each mask bit covers CHANNELS bits.
- Sticky bits: sts_sticky |= masked_event. Bits only clear through clear or reset.
- First fault:
  - If first_valid=0 and any masked_event bit is set, capture that event and set first_valid=1.
  - Captured event is the lowest field index, then the lowest channel within that field.
  - first_ts = ts value sampled at that same edge, i.e. the pre-increment value.
  - While first_valid=1, later events never overwrite the record.
- fault_cnt: +1 on every cycle with any masked_event bit set; holds at all-ones.
- Clear:
  - Zeroes sts_sticky, first_*, fault_cnt and irq.
  - A masked event in the same cycle as clear is applied after the clear: sticky = that event only, first record = that event, fault_cnt = 1.
- Mask changes take effect in the same cycle. Already-latched bits of a field being masked are not cleared.

## Timing
- Reset values: all outputs 0, ts = 0, sts_prev = 0.
- All outputs are registered.
- Latency:
  - An input sampled at edge n appears on sts_sticky, first_*, fault_cnt and irq after edge n (1 cycle).
  - first_ts equals the ts_now value that was visible during the cycle before edge n.
- Reset mid-operation asynchronously forces every register to its reset value. Operation resumes on the first edge after deassertion.
- The block has no backpressure. clear longer than 1 cycle re-clears on each cycle it is high.
- Combinational depth: a priority encoder across NUM_FIELDS*CHANNELS bits, fitting one aclk cycle at ≤1024 bits.

## Test plan
- Reset release with sts_in bit 17 (field 2, ch 1) held high, mask all ones, EDGE_MODE=1 → after the first edge: sticky bit 17 set, first_field=2, first_ch=1, first_ts=0, fault_cnt=1, irq=1. The bit held high on following cycles gives no further count.
- Same-cycle rising edges on field 5 ch 3 and field 1 ch 6 → first record = field 1, ch 6; both sticky bits set; fault_cnt=1.
- Field 4 masked, pulse field 4 ch 0 → no sticky, no irq, fault_cnt=0. Then unmask and pulse again → sticky bit 32 set, irq=1.
- CNT_WIDTH=4, EDGE_MODE=0, hold one bit high for 20 cycles → fault_cnt saturates at 15; first_ts matches the first cycle only.
- Clear asserted in the same cycle as a new event on field 0 ch 0, with an earlier record for field 3 → afterwards sticky = bit 0 only, first_field=0, fault_cnt=1, irq=1.
- TS_WIDTH=8, wait 300 cycles, then an event → first_ts = (cycles since reset − 1) mod 256. Assert aresetn low mid-run → all outputs 0 immediately, without waiting for aclk.
